// File: rtl/norm_seq_divider.sv
// norm_seq_divider: sequential restoring radix-2 divider with leading-zero normalization.
// The divisor is pre-aligned to the dividend's MSB, so only the needed iterations run.
// Optional macro NORM_SEQ_DIVIDER_SIGNED_EN adds an is_signed input and a FIX state for
// two's complement operands (truncating division).
module norm_seq_divider #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
`ifdef NORM_SEQ_DIVIDER_SIGNED_EN
  input  logic         is_signed,
`endif
  output logic         busy
);

  localparam int unsigned CW = $clog2(N) + 1;

`ifdef NORM_SEQ_DIVIDER_SIGNED_EN
  typedef enum logic [2:0] {StIdle, StNorm, StIter, StFix, StDone} state_e;
`else
  typedef enum logic [2:0] {StIdle, StNorm, StIter, StDone} state_e;
`endif

  // Leading-zero count; returns N for a zero input.
  function automatic logic [CW-1:0] lzc(input logic [N-1:0] v);
    logic [CW-1:0] cnt;
    cnt = CW'(N);
    for (int i = 0; i < N; i++) begin
      if (v[i]) cnt = CW'(N - 1 - i);
    end
    return cnt;
  endfunction

  state_e        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  dsh_q, dsh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dbz_q, dbz_d;
`ifdef NORM_SEQ_DIVIDER_SIGNED_EN
  logic          sgn_q, sgn_d;
  logic          negq_q, negq_d;
  logic          negr_q, negr_d;
`endif

  logic [N-1:0]  mag_a, mag_b;
  logic [CW-1:0] lzc_a, lzc_b, shamt;

  // Operand magnitudes and alignment shift, consumed in NORM.
  always_comb begin
    mag_a = a_q;
    mag_b = b_q;
`ifdef NORM_SEQ_DIVIDER_SIGNED_EN
    if (sgn_q && a_q[N-1]) mag_a = -a_q;
    if (sgn_q && b_q[N-1]) mag_b = -b_q;
`endif
    lzc_a = lzc(mag_a);
    lzc_b = lzc(mag_b);
    // Only meaningful when mag_a >= mag_b > 0, which guarantees lzc_b >= lzc_a.
    shamt = lzc_b - lzc_a;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    q_d     = q_q;
    dsh_d   = dsh_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
`ifdef NORM_SEQ_DIVIDER_SIGNED_EN
    sgn_d   = sgn_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = dividend;
          b_d     = divisor;
`ifdef NORM_SEQ_DIVIDER_SIGNED_EN
          sgn_d   = is_signed;
`endif
          state_d = StNorm;
        end
      end
      StNorm: begin
        if (b_q == '0) begin
          q_d     = '1;
          rem_d   = a_q;
          dbz_d   = 1'b1;
          state_d = StDone;
        end else if (mag_a < mag_b) begin
          // Quotient truncates to zero; remainder is the dividend itself (sign included).
          q_d     = '0;
          rem_d   = a_q;
          dbz_d   = 1'b0;
          state_d = StDone;
        end else begin
          q_d     = '0;
          rem_d   = mag_a;
          dsh_d   = mag_b << shamt;
          cnt_d   = shamt + CW'(1);
          dbz_d   = 1'b0;
`ifdef NORM_SEQ_DIVIDER_SIGNED_EN
          negq_d  = sgn_q & (a_q[N-1] ^ b_q[N-1]);
          negr_d  = sgn_q & a_q[N-1];
`endif
          state_d = StIter;
        end
      end
      StIter: begin
        if (rem_q >= dsh_q) begin
          rem_d = rem_q - dsh_q;
          q_d   = {q_q[N-2:0], 1'b1};
        end else begin
          q_d   = {q_q[N-2:0], 1'b0};
        end
        dsh_d = dsh_q >> 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
`ifdef NORM_SEQ_DIVIDER_SIGNED_EN
          state_d = sgn_q ? StFix : StDone;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef NORM_SEQ_DIVIDER_SIGNED_EN
      StFix: begin
        if (negq_q) q_d = -q_q;
        if (negr_q) rem_d = -rem_q;
        state_d = StDone;
      end
`endif
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      dsh_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef NORM_SEQ_DIVIDER_SIGNED_EN
      sgn_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      dsh_q   <= dsh_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
`ifdef NORM_SEQ_DIVIDER_SIGNED_EN
      sgn_q   <= sgn_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
`endif
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = (state_q == StDone);
`ifdef NORM_SEQ_DIVIDER_SIGNED_EN
  assign busy        = (state_q == StNorm) || (state_q == StIter) || (state_q == StFix);
`else
  assign busy        = (state_q == StNorm) || (state_q == StIter);
`endif
  assign quotient    = q_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_norm_seq_divider.sv
// Randomized self-checking bench for norm_seq_divider against an arithmetic reference model.
module tb_norm_seq_divider;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         in_ready, out_valid, div_by_zero, busy;
  logic [N-1:0] quotient, remainder;
`ifdef NORM_SEQ_DIVIDER_SIGNED_EN
  logic         is_signed = 1'b0;
`endif

  int n_checks = 0;
  int n_pass = 0;

  norm_seq_divider #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
`ifdef NORM_SEQ_DIVIDER_SIGNED_EN
    .is_signed  (is_signed),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  function automatic int bitlen(input longint x);
    int n = 0;
    while (x != 0) begin
      x = x >> 1;
      n++;
    end
    return n;
  endfunction

  // Reference: plain 64-bit arithmetic; latency from operand bit lengths.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                       output logic [31:0] q, output logic [31:0] r, output logic z,
                       output int lat);
    longint sa, sb, ma, mb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    if (b == 0) begin
      q = '1; r = a; z = 1'b1; lat = 1;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      z = 1'b0;
      lat = (ma < mb) ? 1 : bitlen(ma) - bitlen(mb) + 2 + (sgn ? 1 : 0);
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                       input int hold);
    logic [31:0] eq, er;
    logic        ez;
    int          elat, edges;
    model(a, b, sgn, eq, er, ez, elat);
    for (int t = 0; t < 10 && !in_ready; t++) begin
      @(posedge clk); #1;
    end
    check("in_ready", in_ready, 1);
    dividend = a;
    divisor  = b;
`ifdef NORM_SEQ_DIVIDER_SIGNED_EN
    is_signed = sgn;
`endif
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    edges = 0;
    while (!out_valid && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    check("latency", edges, elat);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_by_zero", div_by_zero, ez);
    if (!sgn && b != 0) begin
      check("invariant", {32'b0, a}, longint'({32'b0, quotient}) * longint'({32'b0, b})
                                     + longint'({32'b0, remainder}));
      check("rem_lt_div", remainder < b, 1);
    end
    for (int t = 0; t < hold; t++) begin
      in_valid = 1'b1;
      dividend = $urandom;
      divisor  = $urandom | 32'd1;
      @(posedge clk); #1;
      check("hold_quotient", quotient, eq);
      check("hold_remainder", remainder, er);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
    check("idle_after", in_ready, 1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b;
    bit          sgn, seen;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    do_op(32'd100, 32'd7, 1'b0, 0);
    do_op(32'd5, 32'd0, 1'b0, 0);
    do_op(32'd3, 32'd10, 1'b0, 0);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0);
    do_op(32'd100, 32'd7, 1'b0, 5);
    do_op(32'd9, 32'd3, 1'b0, 0);

    // Reset mid-iteration of 1000/3.
    dividend = 32'd1000;
    divisor  = 32'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_quotient", quotient, 0);
    check("mid_rst_remainder", remainder, 0);
    check("mid_rst_dbz", div_by_zero, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("no_valid_after_rst", seen, 0);
    do_op(32'd1000, 32'd3, 1'b0, 0);

`ifdef NORM_SEQ_DIVIDER_SIGNED_EN
    do_op(-32'sd7, 32'd2, 1'b1, 0);
    do_op(32'd7, -32'sd2, 1'b1, 0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    do_op(-32'sd5, 32'd0, 1'b1, 0);
`endif

    for (int i = 0; i < 2000; i++) begin
`ifdef NORM_SEQ_DIVIDER_SIGNED_EN
      sgn = 1'($urandom_range(0, 1));
`else
      sgn = 1'b0;
`endif
      a = $urandom >> $urandom_range(0, 31);
      b = ($urandom_range(0, 31) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      if (sgn && $urandom_range(0, 1) == 1) a = -a;
      if (sgn && $urandom_range(0, 1) == 1) b = -b;
      do_op(a, b, sgn, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
